// File: rtl/oric_tap_pkg.sv
// rtl/oric_tap_pkg.sv - shared constants and frame FSM state for the Oric tape-save decoder
package oric_tap_pkg;
    localparam int PULSE_HI_LEN = 208;
    localparam int PULSE_LO_LEN = 416;

    localparam int DEF_LO_MIN  = 104;
    localparam int DEF_LO_THR  = 312;
    localparam int DEF_LO_MAX  = 624;
    localparam int DEF_TIMEOUT = 4096;

    localparam logic [7:0] SYNC_BYTE        = 8'h16;
    localparam logic [23:0] SQUASH_PTR_LIMIT = 24'd16;
    localparam logic [2:0] SQUASH_MAX_RUN   = 3'd4;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } frame_state_e;
endpackage

// File: rtl/oric_tap_pulse_meter.sv
// rtl/oric_tap_pulse_meter.sv - tape_in synchronizer, level timer and low-phase bit classifier
module oric_tap_pulse_meter
    import oric_tap_pkg::*;
#(
    parameter int LO_MIN  = DEF_LO_MIN,
    parameter int LO_THR  = DEF_LO_THR,
    parameter int LO_MAX  = DEF_LO_MAX,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    input  logic enable,
    input  logic tape_in,
    output logic bit_valid,
    output logic bit_val,
    output logic abort,
    output logic timeout
);
    localparam logic [15:0] MIN_L = 16'(LO_MIN);
    localparam logic [15:0] THR_L = 16'(LO_THR);
    localparam logic [15:0] MAX_L = 16'(LO_MAX);
    localparam logic [15:0] TMO_L = 16'(TIMEOUT);

    logic        sync1_q, sync2_q, prev_q;
    logic [15:0] lvl_q, lvl_d;
    logic        bit_valid_q, bit_val_q, abort_q, timeout_q;
    logic        edge_w, rise_w;

    assign edge_w = sync2_q ^ prev_q;
    assign rise_w = sync2_q & ~prev_q;

    // lvl_q at an edge is the length of the level that just ended
    always_comb begin
        lvl_d = lvl_q;
        if (!enable || edge_w) begin
            lvl_d = '0;
        end else if (ce && lvl_q != 16'hFFFF) begin
            lvl_d = lvl_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            lvl_q       <= '0;
            bit_valid_q <= 1'b0;
            bit_val_q   <= 1'b0;
            abort_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            sync1_q     <= tape_in;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            lvl_q       <= lvl_d;
            bit_valid_q <= enable && rise_w && (lvl_q >= MIN_L) && (lvl_q <= MAX_L);
            bit_val_q   <= (lvl_q < THR_L);
            abort_q     <= enable && rise_w && (lvl_q > MAX_L);
            timeout_q   <= enable && (lvl_q >= TMO_L);
        end
    end

    assign bit_valid = bit_valid_q;
    assign bit_val   = bit_val_q;
    assign abort     = abort_q;
    assign timeout   = timeout_q;
endmodule

// File: rtl/oric_tap_recorder.sv
// rtl/oric_tap_recorder.sv - rebuilds TAP bytes from cassette pulses; optional ORIC_TAP_REC_SYNC_SQUASH_EN
module oric_tap_recorder
    import oric_tap_pkg::*;
#(
    parameter int LO_MIN  = DEF_LO_MIN,
    parameter int LO_THR  = DEF_LO_THR,
    parameter int LO_MAX  = DEF_LO_MAX,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        ce,
    input  logic        reset,
    input  logic        motor_on,
    input  logic        recstop,
    input  logic        tape_in,
    output logic        byte_req,
    input  logic        byte_ack,
    output logic [23:0] byte_addr,
    output logic [7:0]  byte_out,
    output logic        running,
    output logic        parity_err,
    output logic        overrun,
    output logic [23:0] byte_count
);
    frame_state_e state_q, state_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic         par_q, par_d;
    logic [7:0]   shreg_q, shreg_d;
    logic [23:0]  wr_ptr_q, wr_ptr_d;
    logic         req_q, req_d;
    logic [23:0]  addr_q, addr_d;
    logic [7:0]   out_q, out_d;
    logic         perr_q, perr_d;
    logic         ovr_q, ovr_d;
    logic         rec_q, rec_d;
    logic         recstop_q;
    logic         run_w, byte_done, squash;
    logic         bit_valid, bit_val, abort, timeout;
`ifdef ORIC_TAP_REC_SYNC_SQUASH_EN
    logic [2:0]   run_cnt_q, run_cnt_d;
`endif

    assign run_w = motor_on & rec_q;

    oric_tap_pulse_meter #(
        .LO_MIN (LO_MIN),
        .LO_THR (LO_THR),
        .LO_MAX (LO_MAX),
        .TIMEOUT(TIMEOUT)
    ) u_meter (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .enable   (run_w),
        .tape_in  (tape_in),
        .bit_valid(bit_valid),
        .bit_val  (bit_val),
        .abort    (abort),
        .timeout  (timeout)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        shreg_d   = shreg_q;
        wr_ptr_d  = wr_ptr_q;
        req_d     = req_q;
        addr_d    = addr_q;
        out_d     = out_q;
        perr_d    = perr_q;
        ovr_d     = ovr_q;
        rec_d     = rec_q;
        byte_done = 1'b0;
        squash    = 1'b0;
`ifdef ORIC_TAP_REC_SYNC_SQUASH_EN
        run_cnt_d = run_cnt_q;
`endif
        if (!run_w || abort || timeout) begin
            state_d = ST_HUNT;
        end else if (bit_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (!bit_val) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                        par_d     = 1'b1;
                    end
                end
                ST_DATA: begin
                    shreg_d[bit_cnt_q] = bit_val;
                    par_d              = par_q ^ bit_val;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                ST_PARITY: begin
                    state_d   = ST_HUNT;
                    byte_done = 1'b1;
                    if (bit_val != par_q) begin
                        perr_d = 1'b1;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end

        if (byte_done) begin
`ifdef ORIC_TAP_REC_SYNC_SQUASH_EN
            // trims the ROM's long 0x16 leader down to a short run at the start of a file
            squash    = (shreg_q == SYNC_BYTE) && (wr_ptr_q < SQUASH_PTR_LIMIT)
                        && (run_cnt_q >= SQUASH_MAX_RUN);
            run_cnt_d = (shreg_q != SYNC_BYTE) ? 3'd0 :
                        (run_cnt_q == SQUASH_MAX_RUN) ? run_cnt_q : run_cnt_q + 3'd1;
`endif
            if (!squash) begin
                if (req_q == byte_ack) begin
                    out_d    = shreg_q;
                    addr_d   = wr_ptr_q;
                    req_d    = ~req_q;
                    wr_ptr_d = wr_ptr_q + 24'd1;
                end else begin
                    ovr_d = 1'b1;
                end
            end
        end

        if (recstop && !recstop_q) begin
            rec_d = ~rec_q;
            if (!rec_q) begin
                wr_ptr_d = '0;
                perr_d   = 1'b0;
                ovr_d    = 1'b0;
`ifdef ORIC_TAP_REC_SYNC_SQUASH_EN
                run_cnt_d = 3'd0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_HUNT;
            bit_cnt_q <= '0;
            par_q     <= 1'b1;
            shreg_q   <= '0;
            wr_ptr_q  <= '0;
            req_q     <= byte_ack;
            addr_q    <= '0;
            out_q     <= '0;
            perr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            rec_q     <= 1'b0;
            recstop_q <= 1'b0;
`ifdef ORIC_TAP_REC_SYNC_SQUASH_EN
            run_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            shreg_q   <= shreg_d;
            wr_ptr_q  <= wr_ptr_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            out_q     <= out_d;
            perr_q    <= perr_d;
            ovr_q     <= ovr_d;
            rec_q     <= rec_d;
            recstop_q <= recstop;
`ifdef ORIC_TAP_REC_SYNC_SQUASH_EN
            run_cnt_q <= run_cnt_d;
`endif
        end
    end

    assign byte_req   = req_q;
    assign byte_addr  = addr_q;
    assign byte_out   = out_q;
    assign running    = run_w;
    assign parity_err = perr_q;
    assign overrun    = ovr_q;
    assign byte_count = wr_ptr_q;
endmodule

// File: tb/tb_oric_tap_recorder.sv
// tb/tb_oric_tap_recorder.sv - scoreboard bench for oric_tap_recorder (timing scaled by 1/16)
`timescale 1ns/1ps
module tb_oric_tap_recorder;
    // pulse lengths in ce ticks; thresholds handed to the DUT are scaled the same way
    localparam int HI  = 13;
    localparam int LO1 = 13;
    localparam int LO0 = 26;

    logic        clk = 1'b0, ce = 1'b0, reset = 1'b1, motor_on = 1'b0;
    logic        recstop = 1'b0, tape_in = 1'b1, byte_ack = 1'b1;
    logic        byte_req, running, parity_err, overrun;
    logic [23:0] byte_addr, byte_count;
    logic [7:0]  byte_out;

    oric_tap_recorder #(
        .LO_MIN(6), .LO_THR(20), .LO_MAX(39), .TIMEOUT(256)
    ) dut (
        .clk(clk), .ce(ce), .reset(reset), .motor_on(motor_on), .recstop(recstop),
        .tape_in(tape_in), .byte_req(byte_req), .byte_ack(byte_ack),
        .byte_addr(byte_addr), .byte_out(byte_out), .running(running),
        .parity_err(parity_err), .overrun(overrun), .byte_count(byte_count)
    );

    always #5 clk = ~clk;
    initial forever begin
        @(negedge clk);
        ce = ~ce;
    end

    typedef struct packed {
        logic [23:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  exp_ptr = 0;
    int  sync_run = 0;
    bit  ack_hold = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference: which decoded bytes land in memory and where
    function automatic void model_byte(input logic [7:0] d, input bit dropped);
        bit sq = 1'b0;
`ifdef ORIC_TAP_REC_SYNC_SQUASH_EN
        sq = (d == 8'h16) && (exp_ptr < 16) && (sync_run >= 4);
`endif
        if (d == 8'h16) sync_run++;
        else sync_run = 0;
        if (!sq && !dropped) begin
            exp_q.push_back({exp_ptr[23:0], d});
            exp_ptr = (exp_ptr + 1) & 24'hFFFFFF;
        end
    endfunction

    task automatic hold(input logic v, input int n);
        tape_in = v;
        repeat (2 * n) @(negedge clk);
    endtask

    task automatic send_pulse(input int lo_len);
        hold(1'b1, HI);
        hold(1'b0, lo_len);
    endtask

    task automatic send_bit(input logic b);
        send_pulse(b ? LO1 : LO0);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit flip_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ flip_par);
        send_bit(1'b1);
        send_bit(1'b1);
        hold(1'b1, HI);
    endtask

    task automatic pulse_recstop();
        recstop = 1'b1;
        repeat (3) @(negedge clk);
        recstop = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || byte_req !== byte_ack) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, (exp_q.size() == 0 && byte_req === byte_ack)}, 32'd1);
    endtask

    // monitor: every byte_req toggle is one write and must match the head of the scoreboard
    initial begin
        logic prev;
        wait (reset == 1'b0);
        @(negedge clk);
        prev = byte_req;
        forever begin
            @(negedge clk);
            if (byte_req !== prev) begin
                prev = byte_req;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h, none expected", byte_addr, byte_out);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    check("wr_addr", {8'd0, byte_addr}, {8'd0, w.addr});
                    check("wr_data", {24'd0, byte_out}, {24'd0, w.data});
                end
            end
        end
    end

    // memory side: acknowledges after a random latency unless held off
    initial forever begin
        @(negedge clk);
        if (!reset && !ack_hold && byte_req !== byte_ack) begin
            repeat ($urandom_range(1, 20)) @(negedge clk);
            if (!ack_hold) byte_ack = byte_req;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (6) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_byte_req", {31'd0, byte_req}, 32'd1);
        check("rst_byte_addr", {8'd0, byte_addr}, 32'd0);
        check("rst_byte_out", {24'd0, byte_out}, 32'd0);
        check("rst_byte_count", {8'd0, byte_count}, 32'd0);
        check("rst_parity_err", {31'd0, parity_err}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_running", {31'd0, running}, 32'd0);

        motor_on = 1'b1;
        repeat (4) @(negedge clk);
        check("motor_only_not_running", {31'd0, running}, 32'd0);
        pulse_recstop();
        check("running_on", {31'd0, running}, 32'd1);
        hold(1'b1, 40);

        model_byte(8'h24, 0); send_byte(8'h24, 0);
        model_byte(8'hA5, 0); send_byte(8'hA5, 0);
        drain("drain_basic");
        check("basic_parity_err", {31'd0, parity_err}, 32'd0);
        check("basic_count", {8'd0, byte_count}, 32'd2);

        model_byte(8'h00, 0); send_byte(8'h00, 1);
        drain("drain_badpar");
        check("badpar_parity_err", {31'd0, parity_err}, 32'd1);

        ack_hold = 1'b1;
        model_byte(8'h11, 0); send_byte(8'h11, 0);
        model_byte(8'h22, 1); send_byte(8'h22, 0);
        ack_hold = 1'b0;
        repeat (60) @(negedge clk);
        model_byte(8'h33, 0); send_byte(8'h33, 0);
        drain("drain_overrun");
        check("overrun_set", {31'd0, overrun}, 32'd1);

        hold(1'b1, HI); hold(1'b0, 3); hold(1'b1, HI); hold(1'b0, LO1);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_pulse(44);
        hold(1'b1, HI);
        model_byte(8'h5A, 0); send_byte(8'h5A, 0);
        drain("drain_abort");

        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        motor_on = 1'b0;
        hold(1'b1, 300);
        check("motor_off_running", {31'd0, running}, 32'd0);
        hold(1'b1, 325);
        motor_on = 1'b1;
        hold(1'b1, HI);
        model_byte(8'hC3, 0); send_byte(8'hC3, 0);
        drain("drain_motor");

        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        hold(1'b1, 300);
        model_byte(8'h96, 0); send_byte(8'h96, 0);
        drain("drain_timeout");

        for (int i = 0; i < 12; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            model_byte(d, 0);
            send_byte(d, 0);
        end
        drain("drain_random");
        check("sticky_parity_err", {31'd0, parity_err}, 32'd1);
        check("sticky_overrun", {31'd0, overrun}, 32'd1);
        check("random_count", {8'd0, byte_count}, exp_ptr);

        pulse_recstop();
        check("rec_off_running", {31'd0, running}, 32'd0);
        pulse_recstop();
        check("restart_parity_err", {31'd0, parity_err}, 32'd0);
        check("restart_overrun", {31'd0, overrun}, 32'd0);
        check("restart_count", {8'd0, byte_count}, 32'd0);
        exp_ptr = 0;
        sync_run = 0;
        for (int i = 0; i < 6; i++) begin
            model_byte(8'h16, 0);
            send_byte(8'h16, 0);
        end
        model_byte(8'h24, 0); send_byte(8'h24, 0);
        drain("drain_sync");
        check("final_count", {8'd0, byte_count}, exp_ptr);
        check("final_parity_err", {31'd0, parity_err}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/oric_tap_recorder.md
# oric_tap_recorder

Tape-save decoder for the Oric core: measures the pulse train the CPU/VIA drives on the cassette output and rebuilds the TAP byte stream, writing each decoded byte to SDRAM/BRAM through a toggle request/acknowledge port. It decodes the framing the tape player emits: start bit 0, 8 data bits LSB first, odd parity, stop bits 1. Each bit is a 208 µs high followed by a 208 µs (1) or 416 µs (0) low. Sits beside the tape player under the cassette mux, gated by the motor relay.

## Interface
- LO_MIN, 104: shortest low phase (µs) accepted as a bit; shorter is a glitch
- LO_THR, 312: low phase ≥ LO_THR decodes 0, below decodes 1
- LO_MAX, 624: low phase above this aborts the frame
- TIMEOUT, 4096: level held this long (µs) forces HUNT

- clk  in  1  system clock
- ce  in  1  1 µs enable
- reset  in  1  synchronous, active-high
- motor_on  in  1  cassette relay
- recstop  in  1  record toggle; rising edge flips recording
- tape_in  in  1  cassette output from VIA, asynchronous
- byte_req  out  1  toggles once per byte to write
- byte_ack  in  1  memory side copies byte_req when write done
- byte_addr  out  24  write address
- byte_out  out  8  write data
- running  out  1  motor_on & recording
- parity_err  out  1  sticky, parity mismatch seen
- overrun  out  1  sticky, byte dropped while write pending
- byte_count  out  24  bytes written since reset

## Operation
- tape_in passes a 2-flop synchronizer on clk, then an edge detector on clk.
- A 16-bit saturating level counter increments on ce and clears on every edge. Its value at each edge is the length of the level just ended.
- The frame FSM runs only while running. Its states are HUNT, DATA, PARITY.
- A bit is classified at each rising edge (end of low phase), using the low length L:
  - L < LO_MIN: ignored, no state change.
  - LO_MIN ≤ L < LO_THR: bit 1.
  - LO_THR ≤ L ≤ LO_MAX: bit 0.
  - L > LO_MAX: go to HUNT.
- HUNT: 1s are discarded as stop/leader. A 0 is the start bit: go to DATA with bit_cnt=0 and par=1.
- DATA: shift the bit into shreg[bit_cnt] and do par ^= bit. After bit_cnt=7, go to PARITY.
- PARITY: if the received bit ≠ par, set parity_err; the byte is written anyway. Then the byte completes and the FSM goes to HUNT.
- Byte complete:
  - If byte_req == byte_ack: byte_out ← shreg, byte_addr ← wr_ptr, toggle byte_req, wr_ptr++, byte_count++.
  - Otherwise set overrun and drop the byte.
- Timeout: if the level counter reaches TIMEOUT, go to HUNT. wr_ptr is kept.
- Not running (motor off or recording off):
  - FSM forced to HUNT, level counter cleared.
  - wr_ptr, flags and a pending handshake are kept.
- recstop is edge-detected on clk. Each rising edge flips recording. Recording turning on from off clears wr_ptr, byte_count, parity_err and overrun.

## Timing
- Reset values:
  - byte_req ← byte_ack.
  - byte_addr=0, byte_out=0, byte_count=0.
  - parity_err=0, overrun=0, running=0.
  - recording=0, FSM=HUNT.
- The bit decision comes 3 clk after the tape_in rising edge (2 synchronizer stages + edge register).
- byte_req toggles the clk after the parity bit's decision. byte_out and byte_addr are stable from that cycle until byte_ack matches.
- Level counter saturates at 0xFFFF; no wrap.
- wr_ptr wraps from 0xFFFFFF to 0.
- byte_count is tied to wr_ptr.
- If a completed byte and ack arrive in the same clk, the handshake uses the registered equality, so the byte is still written (not counted as overrun).
- A reset mid-byte discards the partial byte. An outstanding request is abandoned by resynchronising byte_req to byte_ack.

## Configuration
- ORIC_TAP_REC_SYNC_SQUASH_EN defined: while wr_ptr < 16, a run of consecutive 0x16 bytes is capped at 4 written bytes; extras are consumed without a write and without incrementing wr_ptr. This undoes the long leader from the ROM.
- Undefined: every decoded byte is written.

## Structure
- Package oric_tap_pkg holds:
  - pulse constants PULSE_HI_LEN=208 and PULSE_LO_LEN=416;
  - default LO_MIN, LO_THR, LO_MAX and TIMEOUT;
  - SYNC_BYTE=8'h16;
  - the frame FSM state enum.
- Sub-module oric_tap_pulse_meter contains the synchronizer, edge detector, level counter and classifier. Outputs: bit_valid, bit_val, abort, timeout.

## Test plan
- Record on, motor on, bytes 0x24 then 0xA5 at nominal pulses, stop bits between → byte_out 0x24 @0, 0xA5 @1, two byte_req toggles, parity_err=0.
- Byte 0x00 sent with the parity bit inverted → byte written, parity_err=1 and stays set until recording restarts.
- Hold byte_ack for 2 byte times while 3 bytes arrive → first byte written, second dropped, overrun=1; third written once ack catches up.
- 50 µs low glitch inside a stop bit, then 700 µs low inside a data bit → glitch ignored; abort to HUNT, no write, the next clean byte at the next address.
- motor_on dropped mid-byte for 10 ms, then restored → partial byte discarded, next full byte written at the next wr_ptr; tape_in held 5 ms → HUNT.
- With SYNC_SQUASH, 40×0x16 then 0x24 → 4 bytes of 0x16 @0–3, 0x24 @4; without the macro, 0x24 @40.
